// File: rtl/mem_subsystem.sv
`default_nettype none
// ============================================================================
// mem_subsystem : MAR/MDR-fronted single-port word RAM with IDLE/ACCESS/DONE
//                 handshake. Optional MEM_WAIT_EN adds WAIT_STATES cycles.
// Revision 1.0
// ============================================================================
module mem_subsystem #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    output logic [31:0]       BusMuxIn_MDR,
    output logic [ADDR_W-1:0] MAR_q,
    output logic              Mem_Busy,
    output logic              Mem_Ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       mdr;
    logic              op_read;
    logic              wait_done;
    logic              start;
    logic              finish;
    logic [IDX_W-1:0]  ram_idx;
    logic [31:0]       ram [DEPTH];

    assign start   = (state == S_IDLE) && (Read || Write);
    assign finish  = (state == S_ACCESS) && wait_done;
    assign ram_idx = IDX_W'(32'(addr) % 32'(DEPTH));

`ifdef MEM_WAIT_EN
    logic [3:0] wait_cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wait_cnt <= 4'd0;
        end else if (start) begin
            wait_cnt <= 4'(WAIT_STATES);
        end else if (state == S_ACCESS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign wait_done = (wait_cnt == 4'd0);
`else
    logic [31:0] unused_wait_states;

    assign unused_wait_states = 32'(WAIT_STATES);
    assign wait_done          = 1'b1;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request held through DONE parks there, so it cannot start a second access.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (Read || Write)   state_nxt = S_ACCESS;
            S_ACCESS: if (wait_done)       state_nxt = S_DONE;
            S_DONE:   if (!Read && !Write) state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mar     <= '0;
            addr    <= '0;
            mdr     <= 32'd0;
            op_read <= 1'b0;
        end else begin
            if (MARin) begin
                mar <= BusMuxOut[ADDR_W-1:0];
            end
            if (start) begin
                addr    <= mar;
                op_read <= Read;
            end
            if (finish && op_read) begin
                mdr <= ram[ram_idx];
            end else if (MDRin && !Read && state != S_ACCESS) begin
                mdr <= BusMuxOut;
            end
        end
    end

    // RAM carries no reset so its contents survive a Reset pulse.
    always_ff @(posedge Clock) begin
        if (finish && !op_read) begin
            ram[ram_idx] <= mdr;
        end
    end

    assign BusMuxIn_MDR = mdr;
    assign MAR_q        = mar;
    assign Mem_Busy     = (state == S_ACCESS);
    assign Mem_Ready    = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_subsystem.sv
`default_nettype none
// ============================================================================
// tb_mem_subsystem : table-driven write/read vectors with a read-data
//                    scoreboard, plus reset, priority and hold sequences.
// Revision 1.0
// ============================================================================
module tb_mem_subsystem;

    localparam int ADDR_W      = 9;
    localparam int DEPTH       = 512;
    localparam int WAIT_STATES = 2;
`ifdef MEM_WAIT_EN
    localparam int LAT = WAIT_STATES + 1;
`else
    localparam int LAT = 1;
`endif

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic [31:0]       BusMuxOut = 32'd0;
    logic              MARin = 1'b0;
    logic              MDRin = 1'b0;
    logic              Read  = 1'b0;
    logic              Write = 1'b0;
    logic [31:0]       BusMuxIn_MDR;
    logic [ADDR_W-1:0] MAR_q;
    logic              Mem_Busy;
    logic              Mem_Ready;

    mem_subsystem #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WAIT_STATES)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .BusMuxOut    (BusMuxOut),
        .MARin        (MARin),
        .MDRin        (MDRin),
        .Read         (Read),
        .Write        (Write),
        .BusMuxIn_MDR (BusMuxIn_MDR),
        .MAR_q        (MAR_q),
        .Mem_Busy     (Mem_Busy),
        .Mem_Ready    (Mem_Ready)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] bus_addr;
        logic [31:0] data;
        logic [8:0]  exp_mar;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] model [DEPTH];
    logic [31:0] sb [$];
    logic [8:0]  m_mar;
    logic [31:0] m_mdr;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_mar(input logic [31:0] bus, input logic [8:0] expv);
        BusMuxOut = bus;
        MARin     = 1'b1;
        tick();
        MARin     = 1'b0;
        m_mar     = expv;
        chk("mar_load", 32'(MAR_q), 32'(expv));
    endtask

    task automatic set_mdr(input logic [31:0] d);
        BusMuxOut = d;
        MDRin     = 1'b1;
        tick();
        MDRin     = 1'b0;
        m_mdr     = d;
        chk("mdr_load", BusMuxIn_MDR, d);
    endtask

    // Starts a request, checks ACCESS entry and latency; leaves the FSM in DONE.
    task automatic start_and_wait(input bit rd, input bit wr);
        int cnt;
        if (rd) sb.push_back(model[m_mar]);
        else if (wr) model[m_mar] = m_mdr;
        Read  = rd;
        Write = wr;
        tick();
        chk("busy_in_access", 32'(Mem_Busy), 32'd1);
        cnt = 0;
        while (!Mem_Ready && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("latency", cnt, LAT);
        chk("busy_in_done", 32'(Mem_Busy), 32'd0);
        if (rd && sb.size() > 0) begin
            m_mdr = sb.pop_front();
            chk("read_data", BusMuxIn_MDR, m_mdr);
        end
    endtask

    task automatic do_access(input bit rd, input bit wr);
        start_and_wait(rd, wr);
        Read  = 1'b0;
        Write = 1'b0;
        tick();
        chk("ready_drop", 32'(Mem_Ready), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0005, 32'hDEAD_BEEF, 9'h005};
        vecs[1] = '{32'h0000_0000, 32'h1111_1111, 9'h000};
        vecs[2] = '{32'h0000_01FF, 32'h2222_2222, 9'h1FF};
        vecs[3] = '{32'h0000_0203, 32'h3333_3333, 9'h003};
        vecs[4] = '{32'h0000_0010, 32'h0000_1234, 9'h010};
        vecs[5] = '{32'h0000_0020, 32'h0000_0000, 9'h020};
        vecs[6] = '{32'hFFFF_F0AA, 32'h5555_AAAA, 9'h0AA};

        // Asynchronous reset: outputs clear before any clock edge.
        #2 Reset = 1'b1;
        #1;
        chk("rst_mar", 32'(MAR_q), 32'd0);
        chk("rst_mdr", BusMuxIn_MDR, 32'd0);
        chk("rst_busy", 32'(Mem_Busy), 32'd0);
        chk("rst_ready", 32'(Mem_Ready), 32'd0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            set_mar(vecs[i].bus_addr, vecs[i].exp_mar);
            set_mdr(vecs[i].data);
            do_access(1'b0, 1'b1);
        end
        for (int i = 0; i < 7; i++) begin
            set_mar(vecs[i].bus_addr, vecs[i].exp_mar);
            set_mdr(32'd0);
            do_access(1'b1, 1'b0);
        end

        // Read and Write together: read wins and RAM keeps its value.
        set_mar(32'h10, 9'h010);
        set_mdr(32'hCAFE_F00D);
        do_access(1'b1, 1'b1);
        chk("both_mdr", BusMuxIn_MDR, 32'h0000_1234);
        set_mdr(32'd0);
        do_access(1'b1, 1'b0);

        // MDRin during ACCESS is ignored.
        set_mar(32'h1FF, 9'h1FF);
        set_mdr(32'h7777_7777);
        Write = 1'b1;
        tick();
        BusMuxOut = 32'h9999_9999;
        MDRin     = 1'b1;
        Write     = 1'b0;
        model[m_mar] = m_mdr;
        while (Mem_Busy) tick();
        MDRin = 1'b0;
        chk("mdr_hold_access", BusMuxIn_MDR, 32'h7777_7777);
        tick();
        set_mdr(32'd0);
        do_access(1'b1, 1'b0);

        // Held Read after DONE: stays ready, no further access.
        set_mar(32'h5, 9'h005);
        set_mdr(32'd0);
        start_and_wait(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_ready", 32'(Mem_Ready), 32'd1);
            chk("hold_busy", 32'(Mem_Busy), 32'd0);
        end
        Read = 1'b0;
        tick();
        chk("hold_release", 32'(Mem_Ready), 32'd0);
        chk("hold_mdr", BusMuxIn_MDR, 32'hDEAD_BEEF);

        // Reset during a write access aborts it; RAM[0x20] stays 0.
        set_mar(32'h20, 9'h020);
        set_mdr(32'hA5A5_A5A5);
        Write = 1'b1;
        tick();
        chk("abort_busy", 32'(Mem_Busy), 32'd1);
        Write = 1'b0;
        Reset = 1'b1;
        #1;
        chk("abort_busy_clr", 32'(Mem_Busy), 32'd0);
        chk("abort_ready_clr", 32'(Mem_Ready), 32'd0);
        chk("abort_mar_clr", 32'(MAR_q), 32'd0);
        chk("abort_mdr_clr", BusMuxIn_MDR, 32'd0);
        #1 Reset = 1'b0;
        tick();
        set_mar(32'h20, 9'h020);
        set_mdr(32'hFFFF_FFFF);
        do_access(1'b1, 1'b0);
        set_mar(32'h203, 9'h003);
        do_access(1'b1, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_subsystem.md
MEM_SUBSYSTEM -- requirements
Module: mem_subsystem

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the MAR width and the word-address width.
REQ-002 Parameter DEPTH, default 512, SHALL set the RAM depth in 32-bit words.
REQ-003 Parameter WAIT_STATES, default 2, SHALL set the extra access cycles when MEM_WAIT_EN is defined; legal range 0-15.
REQ-004 Clock  input  1  SHALL be the system clock; all state SHALL change on its rising edge.
REQ-005 Reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 BusMuxOut  input  32  SHALL be the datapath bus value, the load source for MAR and MDR.
REQ-007 MARin  input  1  SHALL be the MAR load enable from the control unit.
REQ-008 MDRin  input  1  SHALL be the MDR load-from-bus enable from the control unit.
REQ-009 Read  input  1  SHALL be the memory read request level from the control unit.
REQ-010 Write  input  1  SHALL be the memory write request level from the control unit.
REQ-011 BusMuxIn_MDR  output  32  SHALL be the current MDR contents, fed to the bus mux.
REQ-012 MAR_q  output  ADDR_W  SHALL be the current MAR contents.
REQ-013 Mem_Busy  output  1  SHALL be high while an access is in flight (state ACCESS).
REQ-014 Mem_Ready  output  1  SHALL be high while in state DONE.

Function
REQ-015 MARin=1 at an edge SHALL load MAR <= BusMuxOut[ADDR_W-1:0] in any state; an in-flight access SHALL use its captured address.
REQ-016 MDRin=1 with Read=0 at an edge, in any state except ACCESS, SHALL load MDR <= BusMuxOut.
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE; encoding is free.
REQ-018 IDLE, Read=1 or Write=1 at an edge: capture addr <= MAR and op (Read has priority when both are high), load wait counter, go to ACCESS.
REQ-019 ACCESS, counter != 0: decrement counter and stay; Read/Write deassertion SHALL NOT abort the access.
REQ-020 ACCESS, counter == 0, read op: MDR <= RAM[addr], go to DONE.
REQ-021 ACCESS, counter == 0, write op: RAM[addr] <= MDR, go to DONE.
REQ-022 MDRin during ACCESS SHALL be ignored.
REQ-023 DONE, Read=0 and Write=0: go to IDLE.
REQ-024 DONE, either request high: stay in DONE with Mem_Ready held high; a held request SHALL NOT start a second access.
REQ-025 Latency: with the request sampled at edge E0, Mem_Ready SHALL rise after edge E0+WAIT_STATES+1 (macro defined) or after edge E0+1 (macro undefined).
REQ-026 An address >= DEPTH SHALL wrap modulo DEPTH.
REQ-027 RAM contents SHALL be undefined after power-up; no read-before-write protection is provided.

Reset
REQ-028 Reset=1 SHALL force state IDLE, MAR=0, MDR=0, counter=0, Mem_Busy=0 and Mem_Ready=0 immediately, without waiting for Clock.
REQ-029 Reset during ACCESS SHALL abort the access with no RAM write and no MDR update; RAM contents SHALL be retained.

Configuration
REQ-030 Macro MEM_WAIT_EN defined: the counter SHALL load WAIT_STATES on entry to ACCESS.
REQ-031 Macro MEM_WAIT_EN undefined: the counter logic SHALL be omitted, ACCESS SHALL last exactly one cycle, and WAIT_STATES SHALL be ignored.

Verification
REQ-032 Write then read: MAR=0x05, MDR=0xDEADBEEF, Write held until Mem_Ready; then MDR=0 from the bus, Read to DONE -> BusMuxIn_MDR=0xDEADBEEF.
REQ-033 Latency, MEM_WAIT_EN with WAIT_STATES=2 -> Mem_Ready after the 3rd edge following the sample; undefined -> after the 1st edge.
REQ-034 Read=1 and Write=1 together from IDLE at MAR=0x10 holding 0x1234 -> read performed, RAM[0x10] still 0x1234.
REQ-035 Reset pulse during ACCESS of a write of 0xA5A5A5A5 to 0x20 (prior value 0x0) -> RAM[0x20]=0x0, state IDLE, all outputs 0.
REQ-036 BusMuxOut=0x0000_0203 with MARin -> MAR_q=0x003; a read returns RAM[3].
REQ-037 Read held for 10 cycles after DONE -> Mem_Ready stays high and exactly one access occurs; Read drop -> IDLE on the next edge.
